// File: rtl/mod_bandera_pf.sv
// Parity-flag (PF) generator for the ALU flag unit: registered even parity of entrada.
// Define BANDERA_PF_ODD_EN to capture odd parity instead; reset value stays 0 in both builds.
module mod_bandera_pf #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] entrada,
  output logic             out,
  output logic             out_valid
);

  logic w_parity;
  logic r_out;
  logic r_valid;

  // Parity of the result word; every bit has equal weight
  always_comb begin
    w_parity = 1'b0;
`ifdef BANDERA_PF_ODD_EN
    w_parity = ^entrada;
`else
    w_parity = ~^entrada;
`endif
  end

  // Reset has priority; the flag holds when en is low, and valid pulses for one cycle per capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= en;
      if (en) begin
        r_out <= w_parity;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_mod_bandera_pf.sv
// Self-checking bench for mod_bandera_pf: directed steps plus random traffic against a parity model.
// The model follows BANDERA_PF_ODD_EN in the same way as the design.
module tb_mod_bandera_pf;

  localparam int unsigned WIDTH = 6;

  logic             clk;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] entrada;
  logic             out;
  logic             out_valid;

  int checks;
  int errors;
  int ones_seen;

  logic exp_out;
  logic exp_valid;

  mod_bandera_pf #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .entrada   (entrada),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference flag: counts ones arithmetically, then applies the parity sense of this build
  function automatic logic model_flag(input logic [WIDTH-1:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (v[i] == 1'b1) cnt++;
    end
`ifdef BANDERA_PF_ODD_EN
    return (cnt % 2) == 1;
`else
    return (cnt % 2) == 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the same edge, then compare both outputs
  task automatic step(input logic r, input logic e, input logic [WIDTH-1:0] d, input string tag);
    rst     = r;
    en      = e;
    entrada = d;
    @(posedge clk);
    #1;
    if (r) begin
      exp_out   = 1'b0;
      exp_valid = 1'b0;
    end else if (e) begin
      exp_out   = model_flag(d);
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    chk({tag, ".out"}, out, exp_out);
    chk({tag, ".valid"}, out_valid, exp_valid);
  endtask

  logic [WIDTH-1:0] basic_vec [5];
  logic             basic_exp [5];

  initial begin
    checks    = 0;
    errors    = 0;
    ones_seen = 0;
    exp_out   = 1'b0;
    exp_valid = 1'b0;
    rst       = 1'b1;
    en        = 1'b1;
    entrada   = '0;

    basic_vec[0] = 6'b000000;
    basic_vec[1] = 6'b000001;
    basic_vec[2] = 6'b000011;
    basic_vec[3] = 6'b101010;
    basic_vec[4] = 6'b111111;
`ifdef BANDERA_PF_ODD_EN
    basic_exp[0] = 1'b0; basic_exp[1] = 1'b1; basic_exp[2] = 1'b0;
    basic_exp[3] = 1'b1; basic_exp[4] = 1'b0;
`else
    basic_exp[0] = 1'b1; basic_exp[1] = 1'b0; basic_exp[2] = 1'b1;
    basic_exp[3] = 1'b0; basic_exp[4] = 1'b1;
`endif

    // Reset for two cycles with en high: reset wins
    step(1'b1, 1'b1, 6'b000000, "reset0");
    step(1'b1, 1'b1, 6'b000000, "reset1");

    // Basic vectors, back to back, also against hand-derived constants
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, basic_vec[i], $sformatf("basic%0d", i));
      chk($sformatf("basic%0d.const", i), out, basic_exp[i]);
    end

    // Exhaustive sweep of all 64 codes
    for (int v = 0; v < 64; v++) begin
      step(1'b0, 1'b1, WIDTH'(v), $sformatf("sweep%0d", v));
      if (out === 1'b1) ones_seen++;
    end
    chk("sweep.count32", ones_seen == 32, 1'b1);

    // Hold: capture 000001, then en low for three cycles
    step(1'b0, 1'b1, 6'b000001, "hold.cap");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 6'b000000, $sformatf("hold%0d", i));
      chk($sformatf("hold%0d.const", i), out, basic_exp[1]);
    end

    // Reset mid-stream while streaming 000011
    step(1'b0, 1'b1, 6'b000011, "mid.pre");
    step(1'b1, 1'b1, 6'b000011, "mid.rst");
    chk("mid.rst.const", out, 1'b0);
    step(1'b0, 1'b1, 6'b000011, "mid.post");
    chk("mid.post.const", out, basic_exp[2]);

    // Random traffic with occasional reset and idle cycles
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           WIDTH'($urandom), $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
